// File: rtl/ram_port_pkg.sv
// rtl/ram_port_pkg.sv - shared encodings, FSM states and lane-mask helpers for ram_port_adapter
package ram_port_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_BYTE,
    RD_A,
    RD_B,
    RD_CAP,
    FIN
  } state_e;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // Eight bits wide so an access spilling into the next word shows up in [7:4].
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic is_legal_mask(input logic [7:0] mask);
    if (mask[7:4] != 4'b0000) return 1'b0;
    case (mask[3:0])
      MASK_B0, MASK_B1, MASK_B2, MASK_B3, MASK_H0, MASK_H1, MASK_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/ram_load_align.sv
// rtl/ram_load_align.sv - picks the addressed bytes out of two RAM words and extends them
module ram_load_align
  import ram_port_pkg::*;
(
  input  logic [31:0] hi_word_i,
  input  logic [31:0] lo_word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [63:0] both;
  logic [31:0] win;

  always_comb begin
    both = {hi_word_i, lo_word_i};
    win  = both[{off_i, 3'b000} +: 32];
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & win[7]}}, win[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & win[15]}}, win[15:0]};
      default: data_o = win;
    endcase
  end

endmodule

// File: rtl/ram_port_adapter.sv
// rtl/ram_port_adapter.sv - turns byte-addressed loads/stores into legal word-addressed RAM port-A cycles
module ram_port_adapter
  import ram_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [3:0]              ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int BW = ADDR_WIDTH + 2;

  state_e                  state_q, state_d;
  logic [BW-1:0]           addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    mis_q, mis_d;
  logic [1:0]              idx_q, idx_d;
  logic [31:0]             lo_q, lo_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [3:0]              we_q, we_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [31:0]             din_q, din_d;

  logic [7:0]              req_mask;
  logic                    req_aligned;
  logic [BW-1:0]           byte_addr;
  logic [7:0]              wbyte;
  logic [31:0]             align_lo;
  logic [31:0]             align_out;

  assign req_mask    = lane_mask(req_size, req_addr[1:0]);
  assign req_aligned = is_legal_mask(req_mask);
  assign byte_addr   = addr_q + BW'(idx_q);
  assign wbyte       = wdata_q[{idx_q, 3'b000} +: 8];
  assign align_lo    = mis_q ? lo_q : ram_dout;

  ram_load_align u_align (
    .hi_word_i  (ram_dout),
    .lo_word_i  (align_lo),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (align_out)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = 4'b0000;
    raddr_d = raddr_q;
    din_d   = din_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          mis_d   = ~req_aligned;
          raddr_d = req_addr[BW-1:2];
          if (req_size == SZ_ILL) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (req_write && req_aligned) begin
            we_d    = req_mask[3:0];
            din_d   = store_lanes(req_size, req_wdata);
            state_d = FIN;
          end else if (req_write) begin
            we_d    = 4'b0001 << req_addr[1:0];
            din_d   = {4{req_wdata[7:0]}};
            idx_d   = 2'd1;
            state_d = WR_BYTE;
          end else begin
            state_d = RD_A;
          end
        end
      end
      WR_BYTE: begin
        // One lane per cycle; the word address follows the byte address across the boundary.
        we_d    = 4'b0001 << byte_addr[1:0];
        raddr_d = byte_addr[BW-1:2];
        din_d   = {4{wbyte}};
        idx_d   = idx_q + 2'd1;
        if (idx_q == last_byte(size_q)) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RD_A: begin
        if (mis_q) begin
          raddr_d = raddr_q + ADDR_WIDTH'(1);
          state_d = RD_B;
        end else begin
          state_d = RD_CAP;
        end
      end
      RD_B: begin
        lo_d    = ram_dout;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        rdata_d = align_out;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= 2'd0;
      lo_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 4'b0000;
      raddr_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      raddr_q <= raddr_d;
      din_q   <= din_d;
    end
  end

  // The done cycle is already IDLE, so busy has to cover it explicitly.
  assign busy     = (state_q != IDLE) | done_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign ram_we   = we_q;
  assign ram_addr = raddr_q;
  assign ram_din  = din_q;

endmodule

// File: tb/tb_ram_port_adapter.sv
// tb/tb_ram_port_adapter.sv - randomized self-checking bench for ram_port_adapter with a byte-array reference
module tb_ram_port_adapter;

  localparam int AW = 12;
  localparam int BW = AW + 2;
  localparam int NB = 1 << BW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    we;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [BW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          busy, done, err;
  logic [31:0]   rdata;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0]   last_rdata = '0;
  logic [3:0]    first_we;
  logic [AW-1:0] first_addr;
  logic [31:0]   first_din;
  logic [AW-1:0] addr2;
  int            last_wstart;

  always #5 clk = ~clk;

  ram_port_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  function automatic logic [31:0] pat(input int w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // RAM port A: registered read, read output frozen in write cycles, legality of masks tallied.
  logic [31:0] ram_mem [0:(1<<AW)-1];
  logic        loaded = 1'b0;
  wr_t         wlog[$];
  int          bad_mask_cnt = 0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int w = 0; w < (1 << AW); w++) ram_mem[w] <= pat(w);
      loaded <= 1'b1;
    end else if (ram_we != 4'b0000) begin
      for (int l = 0; l < 4; l++)
        if (ram_we[l]) ram_mem[ram_addr][8*l +: 8] <= ram_din[8*l +: 8];
      wlog.push_back('{a: ram_addr, we: ram_we, d: ram_din});
      if (!(ram_we inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
        bad_mask_cnt <= bad_mask_cnt + 1;
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  logic [7:0] ref_mem [0:NB-1];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [BW-1:0] a);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(int'(a) + k) % NB];
    if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [BW-1:0] a, input logic [31:0] wd, input bit noise);
    int n, cyc, exp_lat, wstart, exp_writes, idx;
    bit ill, aligned;
    logic [31:0] exp_rd;
    ill     = (sz == 2'b11);
    n       = nbytes(sz);
    aligned = (sz == 2'b00) || (sz == 2'b01 && a[0] == 1'b0) || (sz == 2'b10 && a[1:0] == 2'b00);
    exp_lat = ill ? 1 : w ? (aligned ? 2 : n + 1) : (aligned ? 3 : 4);
    exp_rd  = (ill || w) ? last_rdata : ref_load(sz, u, a);
    wstart  = wlog.size();
    last_wstart = wstart;

    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = BW'($urandom); req_wdata = $urandom;
    cyc = 1;
    first_we = ram_we; first_addr = ram_addr; first_din = ram_din;
    addr2 = '0;
    while (done !== 1'b1 && cyc < 12) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_mid cycle=%0d got=%b exp=1", cyc, busy);
      end
      if (noise) req_valid = 1'($urandom);
      tick();
      req_valid = 1'b0;
      cyc++;
      if (cyc == 2) addr2 = ram_addr;
    end

    checks++;
    if (done !== 1'b1 || cyc != exp_lat) begin
      failures++;
      $display("FAIL latency w=%0d sz=%0d a=%h got=%0d done=%b exp=%0d", w, sz, a, cyc, done, exp_lat);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_done got=%b exp=1", busy);
    end
    checks++;
    if (err !== ill) begin
      failures++;
      $display("FAIL err sz=%0d got=%b exp=%b", sz, err, ill);
    end
    checks++;
    if (rdata !== exp_rd) begin
      failures++;
      $display("FAIL rdata w=%0d sz=%0d u=%0d a=%h got=%h exp=%h", w, sz, u, a, rdata, exp_rd);
    end

    exp_writes = (w && !ill) ? (aligned ? 1 : n) : 0;
    checks++;
    if (wlog.size() - wstart != exp_writes) begin
      failures++;
      $display("FAIL write_cycles sz=%0d a=%h got=%0d exp=%0d", sz, a, wlog.size() - wstart, exp_writes);
    end
    if (w && !ill) begin
      idx = 0;
      for (int e = wstart; e < wlog.size(); e++)
        for (int l = 0; l < 4; l++)
          if (wlog[e].we[l]) begin
            checks++;
            if (idx >= n || {wlog[e].a, 2'(l)} !== BW'((int'(a) + idx) % NB) ||
                wlog[e].d[8*l +: 8] !== wd[8*idx +: 8]) begin
              failures++;
              $display("FAIL store_byte k=%0d got_addr=%h got=%h exp_addr=%h exp=%h", idx,
                       {wlog[e].a, 2'(l)}, wlog[e].d[8*l +: 8], BW'((int'(a) + idx) % NB),
                       (idx < n) ? wd[8*idx +: 8] : 8'h00);
            end
            idx++;
          end
      checks++;
      if (idx != n) begin
        failures++;
        $display("FAIL store_count got=%0d exp=%0d", idx, n);
      end
      for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % NB] = wd[8*k +: 8];
    end
    checks++;
    if (bad_mask_cnt != 0) begin
      failures++;
      $display("FAIL illegal_mask got=%0d exp=0", bad_mask_cnt);
    end
    last_rdata = exp_rd;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (busy !== 1'b0)   begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0)   begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    if (err !== 1'b0)    begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    if (rdata !== '0)    begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    if (ram_we !== '0)   begin failures++; $display("FAIL rst_we got=%b exp=0", ram_we); end
    if (ram_addr !== '0) begin failures++; $display("FAIL rst_addr got=%h exp=0", ram_addr); end
    if (ram_din !== '0)  begin failures++; $display("FAIL rst_din got=%h exp=0", ram_din); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int exp_a[4];
    logic [3:0] exp_we[4];
    logic [7:0] exp_b[4];
    do_req(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 1'b0);
    checks++;
    if (first_we !== 4'b1111 || first_addr !== 12'd4 || first_din !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_store_c1 got=%b/%h/%h exp=1111/004/deadbeef", first_we, first_addr, first_din);
    end
    do_req(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load got=%h exp=deadbeef", rdata); end

    do_req(1'b1, 2'b00, 1'b0, 14'h013, 32'h123456A5, 1'b0);
    checks++;
    if (first_we !== 4'b1000 || first_din[31:24] !== 8'hA5) begin
      failures++;
      $display("FAIL byte_store_c1 got=%b/%h exp=1000/a5", first_we, first_din[31:24]);
    end
    do_req(1'b0, 2'b00, 1'b0, 14'h013, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'hFFFFFFA5) begin failures++; $display("FAIL byte_load_s got=%h exp=ffffffa5", rdata); end
    do_req(1'b0, 2'b00, 1'b1, 14'h013, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h000000A5) begin failures++; $display("FAIL byte_load_u got=%h exp=000000a5", rdata); end

    do_req(1'b1, 2'b10, 1'b0, 14'h00E, 32'h11223344, 1'b0);
    exp_a  = '{3, 3, 4, 4};
    exp_we = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_b  = '{8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wlog.size() <= last_wstart + i) begin
        failures++;
        $display("FAIL mis_store_seq i=%0d got=missing exp=present", i);
      end else if (int'(wlog[last_wstart+i].a) != exp_a[i] || wlog[last_wstart+i].we !== exp_we[i] ||
                   wlog[last_wstart+i].d[8*(i+2)%32 +: 8] !== exp_b[i]) begin
        failures++;
        $display("FAIL mis_store_seq i=%0d got=%h/%b/%h exp=%0d/%b/%h", i, wlog[last_wstart+i].a,
                 wlog[last_wstart+i].we, wlog[last_wstart+i].d, exp_a[i], exp_we[i], exp_b[i]);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 14'h00E, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h11223344) begin failures++; $display("FAIL mis_word_load got=%h exp=11223344", rdata); end
  endtask

  task automatic test_wrap();
    do_req(1'b1, 2'b00, 1'b0, 14'h3FFF, 32'h00000081, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 14'h0000, 32'h000000FE, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 14'h3FFF, 32'h0, 1'b0);
    checks += 2;
    if (addr2 !== 12'h000) begin failures++; $display("FAIL wrap_addr got=%h exp=000", addr2); end
    if (rdata !== 32'hFFFFFE81) begin failures++; $display("FAIL wrap_half got=%h exp=fffffe81", rdata); end
    do_req(1'b0, 2'b01, 1'b1, 14'h3FFF, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0000FE81) begin failures++; $display("FAIL wrap_half_u got=%h exp=0000fe81", rdata); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 2'b11, 1'b0, 14'h0044, 32'h0, 1'b0);
    checks++;
    if (first_we !== 4'b0000) begin failures++; $display("FAIL illegal_we got=%b exp=0000", first_we); end
    do_req(1'b0, 2'b10, 1'b1, 14'h0010, 32'h0, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 14'h0021, 32'hBEEF7A55, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 14'h0021, 32'h0, 1'b0);
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after got=%b%b exp=00", busy, done);
    end
  endtask

  task automatic test_reset_mid_op();
    int wstart;
    wstart = wlog.size();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 14'h00E; req_wdata = 32'hA1B2C3D4;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ram_we !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || rdata !== '0) begin
      failures++;
      $display("FAIL rst_mid got=we%b busy%b done%b rdata%h exp=we0000 busy0 done0 rdata0", ram_we, busy, done, rdata);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || ram_we !== 4'b0000) begin
        failures++;
        $display("FAIL rst_quiet i=%0d got=done%b we%b exp=done0 we0000", i, done, ram_we);
      end
    end
    checks++;
    if (wlog.size() - wstart != 1 || wlog[wstart].we !== 4'b0100 || wlog[wstart].d[23:16] !== 8'hD4) begin
      failures++;
      $display("FAIL rst_writes got=%0d exp=1 (lane2 d4)", wlog.size() - wstart);
    end
    ref_mem[14'h00E] = 8'hD4;
    last_rdata = '0;
    do_req(1'b0, 2'b10, 1'b0, 14'h00C, 32'h0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 14'h00E, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    logic [1:0] sz;
    logic [BW-1:0] a;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = BW'($urandom_range(0, 63));
      else if (r < 8) a = BW'(NB - 8 + $urandom_range(0, 7));
      else            a = BW'($urandom);
      r  = $urandom_range(0, 7);
      sz = (r == 7) ? 2'b11 : 2'(r % 3);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++) ref_mem[b] = 8'(pat(b >> 2) >> (8 * (b & 3)));
    test_reset();
    test_directed();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
